// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: GF(2^8) arithmetic, MixColumns, round constants and the
// per-stage payload carried down the round pipeline.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RM_PER_XFER = 2'd0,
    RM_FULL     = 2'd1,
    RM_FINAL    = 2'd2
  } round_mode_e;

  typedef struct packed {
    logic [127:0] state;
    logic [127:0] key;
    byte_t        rcon;
    logic         fin;
  } stage_t;

  localparam byte_t RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul2(input byte_t a);
    return xtime(a);
  endfunction

  function automatic byte_t gmul3(input byte_t a);
    return xtime(a) ^ a;
  endfunction

  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic word_t mix_col(input word_t c);
    byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3,
            a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3,
            a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3),
            gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3)};
  endfunction

  // Column c occupies [127-32c -: 32], byte 0 of the column in the top byte.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic stage_t add_round_key(input stage_t s);
    stage_t r;
    r       = s;
    r.state = s.state ^ s.key;
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse (a^254) followed by the affine map,
// computed rather than tabled.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  byte_t sq, inv;

  // inv = a^2 * a^4 * ... * a^128 = a^254; 0 maps to 0
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_round_stage_pipe.sv
// AES-128 round stage: MixColumns + AddRoundKey with on-the-fly key expansion and
// Rcon update, behind an elastic empty/ready pipeline of PIPE_STAGES registers.
module aes_round_stage_pipe
  import aes_pkg::*;
#(
  parameter int PIPE_STAGES = 1,
  parameter int ROUND_MODE  = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_in,
  input  logic         final_in,
  input  logic         empty_in,
  output logic         ready_out,
  output logic [127:0] state_out,
  output logic [127:0] key_out,
  output logic [7:0]   rcon_out,
  output logic         final_out,
  output logic         empty,
  input  logic         ready_in
);

  localparam int S = PIPE_STAGES;

  word_t  w0, w1, w2, w3, rot, sub, t;
  word_t  n0, n1, n2, n3;
  logic   fin;
  stage_t front;

  assign {w0, w1, w2, w3} = key_in;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
  end

  assign t  = sub ^ {rcon_in, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign fin = (ROUND_MODE == int'(RM_FINAL)) ? 1'b1 :
               (ROUND_MODE == int'(RM_FULL))  ? 1'b0 : final_in;

  assign front = '{state: fin ? state_in : mix_columns(state_in),
                   key:   {n0, n1, n2, n3},
                   rcon:  xtime(rcon_in),
                   fin:   fin};

  stage_t       stg_n [1:S];
  stage_t       stg_q [1:S];
  logic [S:1]   vld_q;
  logic [S:0]   vld_pipe;
  logic [S+1:1] rdy;
  logic [S:1]   ld;

  assign vld_pipe = {vld_q, !empty_in};

  // Ready ripples back from ready_in so a full stage that is draining still accepts.
  always_comb begin
    rdy      = '0;
    ld       = '0;
    rdy[S+1] = ready_in;
    for (int k = S; k >= 1; k--) rdy[k] = !vld_q[k] || rdy[k+1];
    for (int k = 1; k <= S; k++) ld[k] = vld_pipe[k-1] && rdy[k];
  end

  for (genvar k = 1; k <= S; k++) begin : g_stage
    stage_t src;
    if (k == 1) begin : g_head
      assign src = front;
    end else begin : g_body
      assign src = stg_q[k-1];
    end
    // AddRoundKey sits in front of the last register
    if (k == S) begin : g_ark
      assign stg_n[k] = add_round_key(src);
    end else begin : g_pass
      assign stg_n[k] = src;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int k = 1; k <= S; k++) stg_q[k] <= '0;
    end else begin
      for (int k = 1; k <= S; k++) begin
        if (ld[k]) begin
          vld_q[k] <= 1'b1;
          stg_q[k] <= stg_n[k];
        end else if (rdy[k+1]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

  assign ready_out = rdy[1];
  assign empty     = !vld_q[S];
  assign state_out = stg_q[S].state;
  assign key_out   = stg_q[S].key;
  assign rcon_out  = stg_q[S].rcon;
  assign final_out = stg_q[S].fin;

endmodule

// File: tb/tb_aes_round_stage_pipe.sv
// Directed bench: FIPS-197 round-1 vectors through 1- and 2-stage pipes and a forced-final
// instance, plus latency, throughput, backpressure and mid-stream reset.
module tb_aes_round_stage_pipe;
  import aes_pkg::*;

  localparam logic [127:0] ST_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] KEY_IN = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         reset_n, final_in, empty_in, ready_in;
  logic [127:0] state_in, key_in;
  logic [7:0]   rcon_in;

  logic         p1_ready_out, p1_final_out, p1_empty;
  logic [127:0] p1_state_out, p1_key_out;
  logic [7:0]   p1_rcon_out;
  logic         p2_ready_out, p2_final_out, p2_empty;
  logic [127:0] p2_state_out, p2_key_out;
  logic [7:0]   p2_rcon_out;
  logic         m2_ready_out, m2_final_out, m2_empty;
  logic [127:0] m2_state_out, m2_key_out;
  logic [7:0]   m2_rcon_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   rc_in   [4];
  logic         fin_in  [4];
  logic [127:0] exp_st  [4];
  logic [127:0] exp_key [4];
  logic [7:0]   exp_rc  [4];
  logic         exp_fin [4];

  always #5 clk = ~clk;

  aes_round_stage_pipe #(.PIPE_STAGES(1), .ROUND_MODE(0)) u_p1 (
    .clock(clk), .reset_n(reset_n), .state_in(state_in), .key_in(key_in), .rcon_in(rcon_in),
    .final_in(final_in), .empty_in(empty_in), .ready_out(p1_ready_out), .state_out(p1_state_out),
    .key_out(p1_key_out), .rcon_out(p1_rcon_out), .final_out(p1_final_out), .empty(p1_empty),
    .ready_in(ready_in));

  aes_round_stage_pipe #(.PIPE_STAGES(2), .ROUND_MODE(0)) u_p2 (
    .clock(clk), .reset_n(reset_n), .state_in(state_in), .key_in(key_in), .rcon_in(rcon_in),
    .final_in(final_in), .empty_in(empty_in), .ready_out(p2_ready_out), .state_out(p2_state_out),
    .key_out(p2_key_out), .rcon_out(p2_rcon_out), .final_out(p2_final_out), .empty(p2_empty),
    .ready_in(ready_in));

  aes_round_stage_pipe #(.PIPE_STAGES(1), .ROUND_MODE(2)) u_m2 (
    .clock(clk), .reset_n(reset_n), .state_in(state_in), .key_in(key_in), .rcon_in(rcon_in),
    .final_in(final_in), .empty_in(empty_in), .ready_out(m2_ready_out), .state_out(m2_state_out),
    .key_out(m2_key_out), .rcon_out(m2_rcon_out), .final_out(m2_final_out), .empty(m2_empty),
    .ready_in(ready_in));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_word(input string tag, input int i, input logic [127:0] st,
                          input logic [127:0] key, input logic [7:0] rc, input logic fn);
    chk($sformatf("%s[%0d].state", tag, i), st,  exp_st[i]);
    chk($sformatf("%s[%0d].key",   tag, i), key, exp_key[i]);
    chk($sformatf("%s[%0d].rcon",  tag, i), rc,  exp_rc[i]);
    chk($sformatf("%s[%0d].final", tag, i), fn,  exp_fin[i]);
  endtask

  task automatic drive(input int i);
    state_in = ST_IN;
    key_in   = KEY_IN;
    rcon_in  = rc_in[i];
    final_in = fin_in[i];
    empty_in = 1'b0;
  endtask

  task automatic idle();
    empty_in = 1'b1;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    rcon_in  = 8'($urandom);
    final_in = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           n_in, n_out;
    logic         stall_prev;
    logic [127:0] st_prev;

    // w0: full round rcon 01; w1: final round; w2: rcon 80 (key top bytes ^81); w3: final, rcon 1B
    rc_in[0] = RCON[0]; fin_in[0] = 1'b0;
    rc_in[1] = RCON[0]; fin_in[1] = 1'b1;
    rc_in[2] = RCON[7]; fin_in[2] = 1'b0;
    rc_in[3] = RCON[8]; fin_in[3] = 1'b1;
    exp_st[0]  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    exp_st[1]  = 128'h7445a32768e07e1f9be228c8344beee0;
    exp_st[2]  = 128'h259c7ff2e99f352bea5bea43836a5049;
    exp_st[3]  = 128'h6e45a32772e07e1f81e228c82e4beee0;
    exp_key[0] = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_key[1] = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_key[2] = 128'h21fafe1709542cb1a2a33939ab6c7605;
    exp_key[3] = 128'hbafafe1792542cb139a33939306c7605;
    exp_rc[0] = 8'h02; exp_rc[1] = 8'h02; exp_rc[2] = 8'h1b; exp_rc[3] = 8'h36;
    exp_fin[0] = 1'b0; exp_fin[1] = 1'b1; exp_fin[2] = 1'b0; exp_fin[3] = 1'b1;

    reset_n  = 1'b0;
    ready_in = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.p2_empty", p2_empty, 1'b1);
    chk("rst.p2_state", p2_state_out, '0);
    chk("rst.p2_key",   p2_key_out, '0);
    chk("rst.p2_rcon",  p2_rcon_out, '0);
    chk("rst.p2_final", p2_final_out, '0);
    chk("rst.p1_empty", p1_empty, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst.p1_ready", p1_ready_out, 1'b1);
    chk("rst.p2_ready", p2_ready_out, 1'b1);

    // single word: latency 1 vs 2, forced-final instance
    drive(0);
    @(negedge clk);
    idle();
    chk("lat.p1_empty", p1_empty, 1'b0);
    chk_word("lat.p1", 0, p1_state_out, p1_key_out, p1_rcon_out, p1_final_out);
    chk("lat.p2_empty_c1", p2_empty, 1'b1);
    chk("m2.state", m2_state_out, exp_st[1]);
    chk("m2.key",   m2_key_out, exp_key[1]);
    chk("m2.final", m2_final_out, 1'b1);
    @(negedge clk);
    chk("lat.p2_empty_c2", p2_empty, 1'b0);
    chk_word("lat.p2", 0, p2_state_out, p2_key_out, p2_rcon_out, p2_final_out);
    chk("lat.p1_drained", p1_empty, 1'b1);
    @(negedge clk);
    chk("lat.p2_drained", p2_empty, 1'b1);

    // back-to-back stream through the single-stage pipe
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        chk("str.p1_empty", p1_empty, 1'b0);
        chk_word("str.p1", i - 1, p1_state_out, p1_key_out, p1_rcon_out, p1_final_out);
      end
      drive(i);
      @(negedge clk);
    end
    chk_word("str.p1", 3, p1_state_out, p1_key_out, p1_rcon_out, p1_final_out);
    idle();
    repeat (3) @(negedge clk);

    // backpressure on the two-stage pipe: ready_in low for three cycles
    n_in = 0;
    n_out = 0;
    stall_prev = 1'b0;
    st_prev = '0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (stall_prev) chk($sformatf("bp.stable_c%0d", c), p2_state_out, st_prev);
      ready_in = !(c inside {[1:3]});
      if (n_in < 4) drive(n_in);
      else idle();
      #1;
      if (!p2_empty && ready_in) begin
        if (n_out < 4) begin
          chk_word("bp.p2", n_out, p2_state_out, p2_key_out, p2_rcon_out, p2_final_out);
          chk($sformatf("bp.out_cycle%0d", n_out), c, 4 + n_out);
        end
        n_out++;
      end
      if (!empty_in && p2_ready_out) n_in++;
      if (c == 2) chk("bp.ready_full", p2_ready_out, 1'b0);
      stall_prev = !p2_empty && !ready_in;
      st_prev    = p2_state_out;
    end
    chk("bp.count_in",  n_in, 4);
    chk("bp.count_out", n_out, 4);

    // reset with both stages of the two-stage pipe full
    @(negedge clk);
    ready_in = 1'b0;
    drive(0);
    @(negedge clk);
    drive(1);
    @(negedge clk);
    idle();
    #1;
    chk("mrst.full_empty", p2_empty, 1'b0);
    chk("mrst.full_ready", p2_ready_out, 1'b0);
    reset_n  = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
    chk("mrst.empty", p2_empty, 1'b1);
    chk("mrst.state", p2_state_out, '0);
    chk("mrst.key",   p2_key_out, '0);
    chk("mrst.rcon",  p2_rcon_out, '0);
    chk("mrst.final", p2_final_out, '0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mrst.no_stale", p2_empty, 1'b1);
    chk("mrst.ready",    p2_ready_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
